// File: rtl/mem_grant_ctrl.sv
// mem_grant_ctrl: weighted round-robin owner of the single mem_ctrl port; rev 1.0.
// Optional watchdog enabled by defining MEM_GRANT_TIMEOUT_EN.
`default_nettype none

module mem_grant_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SRC        = 3,
  parameter int WEIGHT         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*NUM_SRC-1:0]          op_src,
  input  logic [ADDR_WIDTH*NUM_SRC-1:0] raw_address_src,
  input  logic [ADDR_WIDTH*NUM_SRC-1:0] address_offset_src,
  input  logic [512*NUM_SRC-1:0]        common_data_bus_read_in_src,
  output logic [512*NUM_SRC-1:0]        common_data_bus_write_out_src,
  output logic [NUM_SRC-1:0]            tx_done_src,
  output logic [NUM_SRC-1:0]            rd_valid_src,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          timeout_err,
  input  logic [511:0]                  common_data_bus_write_out,
  input  logic                          tx_done,
  input  logic                          rd_valid,
  output logic [1:0]                    op,
  output logic [ADDR_WIDTH-1:0]         raw_address,
  output logic [ADDR_WIDTH-1:0]         address_offset,
  output logic [511:0]                  common_data_bus_read_in
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int TW = $clog2(WEIGHT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        gi_q;
  logic [IW-1:0]        lp_q;
  logic [TW-1:0]        tc_q;
  logic [NUM_SRC-1:0]   grant_q;

  logic [NUM_SRC-1:0]   req;
  logic [1:0]           op_a   [NUM_SRC];
  logic [ADDR_WIDTH-1:0] addr_a [NUM_SRC];
  logic [ADDR_WIDTH-1:0] off_a  [NUM_SRC];
  logic [511:0]         wdat_a [NUM_SRC];
  logic                 busy;

  logic                 sel_any_found;
  logic [IW-1:0]        sel_any;
  logic                 sel_oth_found;
  logic [IW-1:0]        sel_oth;
  logic [IW-1:0]        scan_idx;

  assign busy = (state_q == BUSY);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic route;
    assign route   = busy && (gi_q == IW'(i));
    assign req[i]  = |op_src[2*i +: 2];
    assign op_a[i]   = op_src[2*i +: 2];
    assign addr_a[i] = raw_address_src[ADDR_WIDTH*i +: ADDR_WIDTH];
    assign off_a[i]  = address_offset_src[ADDR_WIDTH*i +: ADDR_WIDTH];
    assign wdat_a[i] = common_data_bus_read_in_src[512*i +: 512];
    assign tx_done_src[i]  = route & tx_done;
    assign rd_valid_src[i] = route & rd_valid;
    assign common_data_bus_write_out_src[512*i +: 512] = route ? common_data_bus_write_out : '0;
  end

  assign op                      = busy ? op_a[gi_q]   : 2'b00;
  assign raw_address             = busy ? addr_a[gi_q] : '0;
  assign address_offset          = busy ? off_a[gi_q]  : '0;
  assign common_data_bus_read_in = busy ? wdat_a[gi_q] : '0;
  assign grant                   = grant_q;

  // Scan lp+1 .. lp+NUM_SRC; the last step revisits lp itself, so "other" stops one short.
  always_comb begin
    sel_any_found = 1'b0;
    sel_any       = '0;
    sel_oth_found = 1'b0;
    sel_oth       = '0;
    scan_idx      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = IW'((int'(lp_q) + k) % NUM_SRC);
      if (!sel_any_found && req[scan_idx]) begin
        sel_any_found = 1'b1;
        sel_any       = scan_idx;
      end
      if (k < NUM_SRC && !sel_oth_found && req[scan_idx]) begin
        sel_oth_found = 1'b1;
        sel_oth       = scan_idx;
      end
    end
  end

`ifdef MEM_GRANT_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WW-1:0] wd_q;
  logic          timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gi_q    <= '0;
      lp_q    <= IW'(NUM_SRC - 1);
      tc_q    <= '0;
      grant_q <= '0;
`ifdef MEM_GRANT_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_GRANT_TIMEOUT_EN
      timeout_err_q <= 1'b0;
      wd_q          <= (busy && !tx_done) ? wd_q + WW'(1) : '0;
`endif
      case (state_q)
        IDLE: begin
          if (sel_any_found) begin
            gi_q    <= sel_any;
            lp_q    <= sel_any;
            tc_q    <= '0;
            grant_q <= NUM_SRC'(1) << sel_any;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (tx_done) begin
            tc_q    <= tc_q + TW'(1);
            state_q <= HOLD;
          end else if (!req[gi_q]) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
`ifdef MEM_GRANT_TIMEOUT_EN
          else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            // Exhaust the turn so a waiting source takes over.
            timeout_err_q <= 1'b1;
            tc_q          <= TW'(WEIGHT);
            state_q       <= HOLD;
          end
`endif
        end
        HOLD: begin
          if (req[gi_q] && (tc_q < TW'(WEIGHT))) begin
            state_q <= BUSY;
          end else if (sel_oth_found) begin
            gi_q    <= sel_oth;
            lp_q    <= sel_oth;
            tc_q    <= '0;
            grant_q <= NUM_SRC'(1) << sel_oth;
            state_q <= BUSY;
          end else if (req[gi_q]) begin
            tc_q    <= '0;
            state_q <= BUSY;
          end else begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_grant_ctrl.sv
// tb_mem_grant_ctrl: scoreboard bench for mem_grant_ctrl (WEIGHT=2, TIMEOUT_CYCLES=16).
`default_nettype none

module tb_mem_grant_ctrl;

  localparam int NS = 3;
  localparam int AW = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2*NS-1:0]     op_src = '0;
  logic [AW*NS-1:0]    raw_address_src = '0;
  logic [AW*NS-1:0]    address_offset_src = '0;
  logic [512*NS-1:0]   rdin_src = '0;
  logic [512*NS-1:0]   wrout_src;
  logic [NS-1:0]       tx_done_src;
  logic [NS-1:0]       rd_valid_src;
  logic [NS-1:0]       grant;
  logic                timeout_err;
  logic [511:0]        wrout = '0;
  logic                tx_done = 1'b0;
  logic                rd_valid = 1'b0;
  logic [1:0]          op;
  logic [AW-1:0]       raw_address;
  logic [AW-1:0]       address_offset;
  logic [511:0]        rdin;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  mem_grant_ctrl #(
    .ADDR_WIDTH(AW), .NUM_SRC(NS), .WEIGHT(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op_src(op_src),
    .raw_address_src(raw_address_src),
    .address_offset_src(address_offset_src),
    .common_data_bus_read_in_src(rdin_src),
    .common_data_bus_write_out_src(wrout_src),
    .tx_done_src(tx_done_src),
    .rd_valid_src(rd_valid_src),
    .grant(grant),
    .timeout_err(timeout_err),
    .common_data_bus_write_out(wrout),
    .tx_done(tx_done),
    .rd_valid(rd_valid),
    .op(op),
    .raw_address(raw_address),
    .address_offset(address_offset),
    .common_data_bus_read_in(rdin)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [1:0] exp_op(input int i);
    return 2'((i % 3) + 1);
  endfunction
  function automatic logic [AW-1:0] exp_addr(input int i);
    return AW'(32'h1000_0000 + i * 256);
  endfunction
  function automatic logic [AW-1:0] exp_off(input int i);
    return AW'(i * 4 + 1);
  endfunction
  function automatic logic [511:0] exp_wd(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction
  function automatic logic [NS-1:0] onehot(input int i);
    return NS'(1) << i;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit on);
    op_src[2*i +: 2] = on ? exp_op(i) : 2'b00;
  endtask

  // Plays mem_ctrl: completes each transaction in its done_at-th BUSY cycle.
  task automatic run_tx(input int n, input int done_at);
    int done_n = 0;
    int busy_c = 0;
    int gap = 0;
    int guard = 0;
    int cur = 0;
    bit started = 1'b0;
    logic [1:0] prev_op = 2'b00;
    while (done_n < n && guard < 500) begin
      cyc();
      guard++;
      tx_done = 1'b0;
      if (op != 2'b00) begin
        if (prev_op == 2'b00) begin
          check("sb_nonempty", 512'(exp_q.size() != 0), 512'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          check("tx_grant", 512'(grant), 512'(onehot(cur)));
          check("tx_op", 512'(op), 512'(exp_op(cur)));
          check("tx_addr", 512'(raw_address), 512'(exp_addr(cur)));
          check("tx_off", 512'(address_offset), 512'(exp_off(cur)));
          check("tx_wdata", rdin, exp_wd(cur));
          if (started) check("hold_len", 512'(gap), 512'd1);
          started = 1'b1;
          busy_c = 0;
          gap = 0;
        end
        busy_c++;
        if (busy_c == done_at) begin
          tx_done = 1'b1;
          #1;
          check("tx_done_src", 512'(tx_done_src), 512'(onehot(cur)));
          done_n++;
        end
      end else if (started) begin
        gap++;
        check("hold_grant", 512'(grant), 512'(onehot(cur)));
      end
      prev_op = op;
    end
    check("run_tx_done", 512'(done_n), 512'(n));
    cyc();
    tx_done = 1'b0;
  endtask

  initial begin
    int pulses;
    int pulse_at;
    for (int i = 0; i < NS; i++) begin
      raw_address_src[AW*i +: AW]    = exp_addr(i);
      address_offset_src[AW*i +: AW] = exp_off(i);
      rdin_src[512*i +: 512]         = exp_wd(i);
    end

    // Reset state, with mem_ctrl strobes that must be ignored.
    tx_done = 1'b1;
    rd_valid = 1'b1;
    repeat (3) cyc();
    check("rst_grant", 512'(grant), 512'd0);
    check("rst_op", 512'(op), 512'd0);
    check("rst_timeout", 512'(timeout_err), 512'd0);
    check("rst_txd_src", 512'(tx_done_src), 512'd0);
    tx_done = 1'b0;
    rd_valid = 1'b0;
    rst_n = 1'b1;

    // Single transaction from src0.
    cyc();
    set_req(0, 1'b1);
    cyc();
    check("t1_grant", 512'(grant), 512'b001);
    check("t1_op", 512'(op), 512'(exp_op(0)));
    check("t1_addr", 512'(raw_address), 512'(exp_addr(0)));
    repeat (3) cyc();
    check("t1_op_held", 512'(op), 512'(exp_op(0)));
    cyc();
    tx_done = 1'b1;
    #1;
    check("t1_txd_src", 512'(tx_done_src), 512'b001);
    check("t1_rdv_src", 512'(rd_valid_src), 512'd0);
    cyc();
    check("t1_hold_op", 512'(op), 512'd0);
    check("t1_hold_grant", 512'(grant), 512'b001);
    #1;
    check("t1_hold_txd_drop", 512'(tx_done_src), 512'd0);
    set_req(0, 1'b0);
    cyc();
    tx_done = 1'b0;
    check("t1_idle_grant", 512'(grant), 512'd0);

    // Reset asserted mid-BUSY acts immediately.
    set_req(1, 1'b1);
    cyc();
    check("rb_grant", 512'(grant), 512'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_grant_async", 512'(grant), 512'd0);
    check("rb_op_async", 512'(op), 512'd0);
    cyc();
    for (int i = 0; i < NS; i++) set_req(i, 1'b1);
    cyc();
    rst_n = 1'b1;

    // All three request: two transactions per turn, starting at src0.
    exp_q = '{0, 0, 1, 1, 2, 2, 0};
    run_tx(7, 3);
    op_src = '0;
    cyc();
    check("rr_idle_grant", 512'(grant), 512'd0);
    check("rr_sb_empty", 512'(exp_q.size()), 512'd0);

    // Lone src1 keeps the port: only HOLD gaps, never IDLE.
    set_req(1, 1'b1);
    for (int k = 0; k < 6; k++) exp_q.push_back(1);
    run_tx(6, 2);
    set_req(1, 1'b0);
    cyc();
    check("solo_idle_grant", 512'(grant), 512'd0);

    // Read data and completion routed only to src2.
    set_req(2, 1'b1);
    cyc();
    check("rd_grant", 512'(grant), 512'b100);
    wrout = {64{8'hA5}};
    rd_valid = 1'b1;
    tx_done = 1'b1;
    #1;
    for (int i = 0; i < NS; i++)
      check($sformatf("rd_slice%0d", i), wrout_src[512*i +: 512], (i == 2) ? {64{8'hA5}} : 512'd0);
    check("rd_valid_src", 512'(rd_valid_src), 512'b100);
    check("rd_txd_src", 512'(tx_done_src), 512'b100);
    cyc();
    tx_done = 1'b0;
    set_req(2, 1'b0);
    #1;
    check("rd_hold_valid_drop", 512'(rd_valid_src), 512'd0);
    check("rd_hold_data_drop", 512'(wrout_src), 512'd0);
    cyc();
    rd_valid = 1'b0;
    wrout = '0;

    // Stuck src0 with src1 waiting.
    set_req(0, 1'b1);
    cyc();
    check("wd_grant", 512'(grant), 512'b001);
    set_req(1, 1'b1);
    pulses = 0;
    pulse_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (timeout_err) begin
        pulses++;
        pulse_at = k;
      end
`ifdef MEM_GRANT_TIMEOUT_EN
      if (k == 17) check("wd_regrant", 512'(grant), 512'b010);
`endif
    end
`ifdef MEM_GRANT_TIMEOUT_EN
    check("wd_pulses", 512'(pulses), 512'd1);
    check("wd_pulse_cycle", 512'(pulse_at), 512'd16);
`else
    check("wd_pulses", 512'(pulses), 512'd0);
    check("wd_still_granted", 512'(grant), 512'b001);
`endif
    // Op withdrawn without completion returns to IDLE.
    op_src = '0;
    cyc();
    check("drop_idle_grant", 512'(grant), 512'd0);
    check("drop_idle_op", 512'(op), 512'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
